// File: rtl/icetap_capture_seq.sv
// Capture controller: pre-trigger ring, staged trigger sequence and per-signal store qualifier.
// A sample reaches the write port two clocks after it is on signals_in. No backpressure: the RAM always accepts a write.
module icetap_capture_seq #(
  parameter  int NR_SIGNALS   = 16,
  parameter  int RECORD_DEPTH = 256,
  parameter  int NR_STAGES    = 4,
  parameter  int CNT_BITS     = 8,
  localparam int ADDR_BITS    = $clog2(RECORD_DEPTH),
  localparam int STG_BITS     = (NR_STAGES > 1) ? $clog2(NR_STAGES) : 1
) (
  input  logic                              src_clk,
  input  logic                              src_reset,
  input  logic [NR_SIGNALS-1:0]             signals_in,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              store_always,
  input  logic                              trigger_always,
  input  logic [3*NR_SIGNALS-1:0]           store_mask_vec,
  input  logic [3*NR_SIGNALS*NR_STAGES-1:0] stage_mask_vec,
  input  logic [CNT_BITS*NR_STAGES-1:0]     stage_count_vec,
  input  logic [STG_BITS-1:0]               stage_last,
  input  logic [ADDR_BITS-1:0]              pre_depth,
  output logic                              wr_ena,
  output logic [ADDR_BITS-1:0]              wr_addr,
  output logic [NR_SIGNALS-1:0]             wr_data,
  output logic [1:0]                        state,
  output logic [STG_BITS-1:0]               cur_stage,
  output logic [ADDR_BITS-1:0]              start_addr,
  output logic [ADDR_BITS-1:0]              trigger_addr,
  output logic [ADDR_BITS-1:0]              stop_addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = ADDR_BITS'(RECORD_DEPTH - 1);
  localparam logic [STG_BITS-1:0]  STG_ONE  = STG_BITS'(1);
  localparam logic [STG_BITS-1:0]  STG_MAX  = STG_BITS'(NR_STAGES - 1);
  localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);

  state_t                fsm;
  logic [NR_SIGNALS-1:0] p1, p2;
  logic [ADDR_BITS-1:0]  wptr, fill, post_left, pre_lat;
  logic [STG_BITS-1:0]   last_lat;
  logic [CNT_BITS-1:0]   match_cnt;

  logic [3*NR_SIGNALS-1:0] stg_mask;
  logic [CNT_BITS-1:0]     stg_cnt, cnt_need;
  logic                    store_cond, stage_hit, stage_done, trig_now;

  function automatic logic code_care(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd5);
  endfunction

  function automatic logic code_match(input logic [2:0] code, input logic cur, input logic prev);
    logic m;
    m = 1'b0;
    case (code)
      3'd1:    m = cur;
      3'd2:    m = !cur;
      3'd3:    m = cur && !prev;
      3'd4:    m = !cur && prev;
      3'd5:    m = cur ^ prev;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  always_comb begin
    stg_mask = '0;
    stg_cnt  = '0;
    for (int k = 0; k < NR_STAGES; k++) begin
      if (cur_stage == STG_BITS'(k)) begin
        stg_mask = stage_mask_vec[k*3*NR_SIGNALS +: 3*NR_SIGNALS];
        stg_cnt  = stage_count_vec[k*CNT_BITS +: CNT_BITS];
      end
    end
    store_cond = store_always;
    stage_hit  = 1'b1;
    for (int i = 0; i < NR_SIGNALS; i++) begin
      if (code_care(store_mask_vec[3*i +: 3]))
        store_cond = store_cond | code_match(store_mask_vec[3*i +: 3], p1[i], p2[i]);
      if (code_care(stg_mask[3*i +: 3]))
        stage_hit = stage_hit & code_match(stg_mask[3*i +: 3], p1[i], p2[i]);
    end
    // A programmed count of zero behaves as one.
    cnt_need   = (stg_cnt == '0) ? CNT_ONE : stg_cnt;
    stage_done = stage_hit && ((match_cnt + CNT_ONE) == cnt_need);
    trig_now   = trigger_always || (stage_done && (cur_stage == last_lat));
  end

  assign state = fsm;

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      fsm          <= IDLE;
      p1           <= '0;
      p2           <= '0;
      wptr         <= '0;
      fill         <= '0;
      post_left    <= '0;
      pre_lat      <= '0;
      last_lat     <= '0;
      match_cnt    <= '0;
      cur_stage    <= '0;
      wr_ena       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      start_addr   <= '0;
      trigger_addr <= '0;
      stop_addr    <= '0;
    end else begin
      p1     <= signals_in;
      p2     <= p1;
      wr_ena <= 1'b0;
      if (abort) begin
        fsm <= IDLE;
      end else begin
        case (fsm)
          IDLE, DONE: begin
            if (start) begin
              fsm       <= PRE;
              wptr      <= '0;
              fill      <= '0;
              cur_stage <= '0;
              match_cnt <= '0;
              pre_lat   <= pre_depth;
              last_lat  <= (stage_last > STG_MAX) ? STG_MAX : stage_last;
            end
          end
          PRE: begin
            if (trig_now) begin
              // The trigger sample is recorded even when the store qualifier is false.
              wr_ena       <= 1'b1;
              wr_addr      <= wptr;
              wr_data      <= p1;
              wptr         <= wptr + ADDR_ONE;
              trigger_addr <= wptr;
              start_addr   <= wptr - fill;
              post_left    <= ADDR_MAX - fill;
              if (fill == ADDR_MAX) begin
                fsm       <= DONE;
                stop_addr <= wptr;
              end else begin
                fsm <= POST;
              end
            end else begin
              if (store_cond) begin
                wr_ena  <= 1'b1;
                wr_addr <= wptr;
                wr_data <= p1;
                wptr    <= wptr + ADDR_ONE;
                if (fill != pre_lat) fill <= fill + ADDR_ONE;
              end
              if (stage_hit) begin
                if (stage_done) begin
                  cur_stage <= cur_stage + STG_ONE;
                  match_cnt <= '0;
                end else begin
                  match_cnt <= match_cnt + CNT_ONE;
                end
              end
            end
          end
          POST: begin
            if (store_cond) begin
              wr_ena    <= 1'b1;
              wr_addr   <= wptr;
              wr_data   <= p1;
              wptr      <= wptr + ADDR_ONE;
              post_left <= post_left - ADDR_ONE;
              if (post_left == ADDR_ONE) begin
                stop_addr <= wptr;
                fsm       <= DONE;
              end
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icetap_capture_seq.sv
// Directed bench for icetap_capture_seq with a 16-entry record and four trigger stages.
module tb_icetap_capture_seq;

  localparam int NS = 16;
  localparam int RD = 16;
  localparam int NST = 4;
  localparam int CB = 8;
  localparam int AB = 4;
  localparam int SB = 2;

  logic                  src_clk = 1'b0;
  logic                  src_reset;
  logic [NS-1:0]         signals_in;
  logic                  start, abort, store_always, trigger_always;
  logic [3*NS-1:0]       store_mask_vec;
  logic [3*NS*NST-1:0]   stage_mask_vec;
  logic [CB*NST-1:0]     stage_count_vec;
  logic [SB-1:0]         stage_last;
  logic [AB-1:0]         pre_depth;
  logic                  wr_ena;
  logic [AB-1:0]         wr_addr;
  logic [NS-1:0]         wr_data;
  logic [1:0]            state;
  logic [SB-1:0]         cur_stage;
  logic [AB-1:0]         start_addr, trigger_addr, stop_addr;

  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int low2_cnt = 0;
  logic [NS-1:0] mem [RD];
  logic [8:0] s0pat, s1pat;

  icetap_capture_seq #(.NR_SIGNALS(NS), .RECORD_DEPTH(RD), .NR_STAGES(NST), .CNT_BITS(CB)) dut (
    .src_clk(src_clk), .src_reset(src_reset), .signals_in(signals_in), .start(start), .abort(abort),
    .store_always(store_always), .trigger_always(trigger_always), .store_mask_vec(store_mask_vec),
    .stage_mask_vec(stage_mask_vec), .stage_count_vec(stage_count_vec), .stage_last(stage_last),
    .pre_depth(pre_depth), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data), .state(state),
    .cur_stage(cur_stage), .start_addr(start_addr), .trigger_addr(trigger_addr), .stop_addr(stop_addr)
  );

  always #5 src_clk = ~src_clk;

  // RAM model fed from the write port, sampled mid-cycle.
  always @(negedge src_clk) begin
    if (wr_ena) begin
      mem[wr_addr] = wr_data;
      wr_cnt++;
      if (!wr_data[2]) low2_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  task automatic do_reset();
    src_reset = 1'b1;
    signals_in = '0; start = 1'b0; abort = 1'b0;
    store_always = 1'b0; trigger_always = 1'b0;
    store_mask_vec = '0; stage_mask_vec = '0; stage_count_vec = '0;
    stage_last = '0; pre_depth = '0;
    tick(); tick();
    src_reset = 1'b0;
    wr_cnt = 0; low2_cnt = 0;
    for (int k = 0; k < RD; k++) mem[k] = '0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_wr_ena", 32'(wr_ena), 0);
    check_eq("rst_wr_addr", 32'(wr_addr), 0);
    check_eq("rst_wr_data", 32'(wr_data), 0);
    check_eq("rst_cur_stage", 32'(cur_stage), 0);
    check_eq("rst_start", 32'(start_addr), 0);
    check_eq("rst_trig", 32'(trigger_addr), 0);
    check_eq("rst_stop", 32'(stop_addr), 0);

    // Forced trigger after four pre samples, ramp data
    stage_mask_vec[15*3 +: 3] = 3'd1;
    store_always = 1'b1; pre_depth = 4'd4;
    for (int i = 0; i < 26; i++) begin
      signals_in = 16'(100 + i); start = (i == 0); trigger_always = (i == 5);
      tick();
    end
    start = 1'b0; trigger_always = 1'b0;
    check_eq("t1_state", 32'(state), 3);
    check_eq("t1_start", 32'(start_addr), 0);
    check_eq("t1_trig", 32'(trigger_addr), 4);
    check_eq("t1_stop", 32'(stop_addr), 15);
    check_eq("t1_writes", 32'(wr_cnt), 16);
    for (int k = 0; k < RD; k++) check_eq($sformatf("t1_mem%0d", k), 32'(mem[k]), 32'(100 + k));

    // Two-stage sequence: third rise of sig0, then sig1 high
    do_reset();
    stage_mask_vec[0 +: 3] = 3'd3;
    stage_mask_vec[48 + 3 +: 3] = 3'd1;
    stage_count_vec = {8'd0, 8'd0, 8'd1, 8'd3};
    stage_last = 2'd1; pre_depth = 4'd3; store_always = 1'b1;
    s0pat = 9'b001101010;
    s1pat = 9'b100011001;
    for (int i = 0; i < 31; i++) begin
      signals_in = {8'(i), 6'b0, (i < 9) ? s1pat[i] : 1'b0, (i < 9) ? s0pat[i] : 1'b0};
      start = (i == 0);
      tick();
      if (i == 5) check_eq("t2_stage_before", 32'(cur_stage), 0);
      if (i == 6) check_eq("t2_stage_after", 32'(cur_stage), 1);
      if (i == 8) check_eq("t2_pre_state", 32'(state), 1);
      if (i == 9) check_eq("t2_post_state", 32'(state), 2);
    end
    start = 1'b0;
    check_eq("t2_state", 32'(state), 3);
    check_eq("t2_trig", 32'(trigger_addr), 8);
    check_eq("t2_start", 32'(start_addr), 5);
    check_eq("t2_stop", 32'(stop_addr), 4);
    check_eq("t2_writes", 32'(wr_cnt), 21);
    check_eq("t2_trig_sample", 32'(mem[8][15:8]), 8);
    check_eq("t2_oldest_sample", 32'(mem[5][15:8]), 5);
    check_eq("t2_last_sample", 32'(mem[4][15:8]), 20);

    // Store qualifier on sig2 high; trigger sample has sig2 low
    do_reset();
    stage_mask_vec[15*3 +: 3] = 3'd1;
    store_mask_vec[2*3 +: 3] = 3'd1;
    pre_depth = 4'd2;
    for (int i = 0; i < 36; i++) begin
      signals_in = {8'(i), 5'b0, (i < 4) ? ((i % 2) == 0) : ((i % 3) != 0), 2'b00};
      start = (i == 0); trigger_always = (i == 4);
      tick();
    end
    start = 1'b0; trigger_always = 1'b0;
    check_eq("t3_state", 32'(state), 3);
    check_eq("t3_trig", 32'(trigger_addr), 2);
    check_eq("t3_start", 32'(start_addr), 0);
    check_eq("t3_stop", 32'(stop_addr), 15);
    check_eq("t3_writes", 32'(wr_cnt), 16);
    check_eq("t3_low_writes", 32'(low2_cnt), 1);
    check_eq("t3_trig_sample", 32'(mem[2]), 32'({8'd3, 8'd0}));
    check_eq("t3_post_first", 32'(mem[3][15:8]), 4);
    check_eq("t3_post_skip", 32'(mem[5][15:8]), 7);
    check_eq("t3_post_last", 32'(mem[15][15:8]), 22);

    // Full pre-trigger depth: trigger goes straight to DONE
    do_reset();
    stage_mask_vec[15*3 +: 3] = 3'd1;
    store_always = 1'b1; pre_depth = 4'd15;
    for (int i = 0; i < 46; i++) begin
      signals_in = {8'(i), 8'd0};
      start = (i == 0); trigger_always = (i == 41);
      tick();
      if (i == 41) check_eq("t4_done_now", 32'(state), 3);
    end
    start = 1'b0; trigger_always = 1'b0;
    check_eq("t4_writes", 32'(wr_cnt), 41);
    check_eq("t4_trig", 32'(trigger_addr), 8);
    check_eq("t4_stop", 32'(stop_addr), 8);
    check_eq("t4_start", 32'(start_addr), 9);
    check_eq("t4_trig_sample", 32'(mem[8][15:8]), 40);
    check_eq("t4_oldest_sample", 32'(mem[9][15:8]), 25);

    // Zero counts on all four stages, then abort, start+abort, reset in PRE
    do_reset();
    for (int k = 0; k < NST; k++) stage_mask_vec[k*48 +: 3] = 3'd1;
    stage_last = 2'd3; pre_depth = 4'd0; store_always = 1'b1;
    for (int i = 0; i < 8; i++) begin
      signals_in = {8'(i), 7'd0, (i >= 2)};
      start = (i == 0);
      tick();
      if (i == 2) check_eq("t5_stage0", 32'(cur_stage), 0);
      if (i == 3) check_eq("t5_stage1", 32'(cur_stage), 1);
      if (i == 4) check_eq("t5_stage2", 32'(cur_stage), 2);
      if (i == 5) check_eq("t5_stage3", 32'(cur_stage), 3);
      if (i == 6) check_eq("t5_post", 32'(state), 2);
    end
    start = 1'b0;
    check_eq("t5_trig", 32'(trigger_addr), 5);
    check_eq("t5_start", 32'(start_addr), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_state", 32'(state), 0);
    check_eq("abort_wr_ena", 32'(wr_ena), 0);
    check_eq("abort_keep_trig", 32'(trigger_addr), 5);
    start = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("start_abort_idle", 32'(state), 0);
    tick();
    start = 1'b0;
    check_eq("rearm_pre", 32'(state), 1);
    tick();
    check_eq("pre_writing", 32'(wr_ena), 1);
    src_reset = 1'b1;
    tick();
    src_reset = 1'b0;
    check_eq("reset_pre_state", 32'(state), 0);
    check_eq("reset_pre_wr_ena", 32'(wr_ena), 0);
    check_eq("reset_pre_trig", 32'(trigger_addr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
